// File: rtl/pc_fetch_seq.sv
// rtl/pc_fetch_seq.sv - front-end fetch PC sequencer with redirect/stale tracking
module pc_fetch_seq #(
  parameter int PC_W        = 48,
  parameter int FETCH_BYTES = 64,
  parameter int IDX_LO      = 3,
  parameter int IDX_HI      = 21
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PC_W-1:0]          boot_addr,
  input  logic                     fetch_inst,
  input  logic                     interrupt_valid,
  input  logic [PC_W-1:0]          interrupt_addr,
  input  logic                     redirect_valid,
  input  logic [PC_W-1:0]          redirect_addr,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [IDX_HI-IDX_LO:0]   req_index,
  input  logic                     req_done,
  output logic                     resp_keep,
  output logic                     resp_drop,
  output logic                     can_fetch_inst,
  output logic [PC_W-1:0]          cur_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Clears the in-block offset bits so every PC is FETCH_BYTES-aligned.
  localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(FETCH_BYTES) - PC_W'(1));
  localparam logic [PC_W-1:0] PC_STEP    = PC_W'(FETCH_BYTES);

  state_t          state;
  logic            stale;
  logic            redir;
  logic [PC_W-1:0] redir_tgt;

  // Interrupt wins over a branch redirect when both arrive together.
  always_comb begin
    redir     = interrupt_valid | redirect_valid;
    redir_tgt = (interrupt_valid ? interrupt_addr : redirect_addr) & ALIGN_MASK;
  end

  // Sequencer FSM: owns pc, the request handshake and the keep/drop verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      stale          <= 1'b0;
      cur_pc         <= boot_addr & ALIGN_MASK;
      req_valid      <= 1'b0;
      req_index      <= '0;
      resp_keep      <= 1'b0;
      resp_drop      <= 1'b0;
      can_fetch_inst <= 1'b1;
    end else begin
      resp_keep <= 1'b0;
      resp_drop <= 1'b0;
      // A redirect always retargets pc; the WAIT/done case below may refine it.
      if (redir) begin
        cur_pc <= redir_tgt;
      end
      case (state)
        IDLE: begin
          // A redirect in the same cycle swallows fetch_inst so we never fetch the old pc.
          if (!redir && fetch_inst) begin
            req_index      <= cur_pc[IDX_HI:IDX_LO];
            req_valid      <= 1'b1;
            can_fetch_inst <= 1'b0;
            state          <= REQ;
          end
        end
        REQ: begin
          // The request cannot be retracted, so a redirect only marks the result stale.
          if (redir) begin
            stale <= 1'b1;
          end
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (req_done) begin
            if (!stale && !redir) begin
              cur_pc    <= cur_pc + PC_STEP;
              resp_keep <= 1'b1;
            end else begin
              resp_drop <= 1'b1;
            end
            stale          <= 1'b0;
            can_fetch_inst <= 1'b1;
            state          <= IDLE;
          end else if (redir) begin
            stale <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          req_valid      <= 1'b0;
          stale          <= 1'b0;
          can_fetch_inst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// tb/tb_pc_fetch_seq.sv - randomized self-checking bench for pc_fetch_seq
module tb_pc_fetch_seq;
  localparam int PC_W = 48;
  localparam int FB   = 64;
  localparam int LO   = 3;
  localparam int HI   = 21;
  localparam int IW   = HI - LO + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [PC_W-1:0] boot_addr;
  logic            fetch_inst;
  logic            interrupt_valid;
  logic [PC_W-1:0] interrupt_addr;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_addr;
  logic            req_valid;
  logic            req_ready;
  logic [IW-1:0]   req_index;
  logic            req_done;
  logic            resp_keep;
  logic            resp_drop;
  logic            can_fetch_inst;
  logic [PC_W-1:0] cur_pc;

  int checks = 0;
  int errors = 0;

  // Reference model state: where the outstanding fetch stands, at transaction level.
  logic [PC_W-1:0] m_pc;
  bit              m_requesting;
  bit              m_accepted;
  bit              m_stale;
  logic [IW-1:0]   m_idx;
  bit              m_keep;
  bit              m_drop;

  always #5 clk = ~clk;

  pc_fetch_seq #(.PC_W(PC_W), .FETCH_BYTES(FB), .IDX_LO(LO), .IDX_HI(HI)) dut (
    .clk(clk), .rst_n(rst_n), .boot_addr(boot_addr), .fetch_inst(fetch_inst),
    .interrupt_valid(interrupt_valid), .interrupt_addr(interrupt_addr),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_done(req_done), .resp_keep(resp_keep), .resp_drop(resp_drop),
    .can_fetch_inst(can_fetch_inst), .cur_pc(cur_pc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PC_W-1:0] align(input logic [PC_W-1:0] a);
    return a - (a % FB);
  endfunction

  task automatic model_reset();
    m_pc = align(boot_addr);
    m_requesting = 0;
    m_accepted = 0;
    m_stale = 0;
    m_idx = '0;
    m_keep = 0;
    m_drop = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit              redir;
    logic [PC_W-1:0] tgt;
    redir = interrupt_valid || redirect_valid;
    tgt = align(interrupt_valid ? interrupt_addr : redirect_addr);
    m_keep = 0;
    m_drop = 0;
    if (!m_requesting && !m_accepted) begin
      if (redir) m_pc = tgt;
      else if (fetch_inst) begin
        m_idx = IW'(m_pc >> LO);
        m_requesting = 1;
      end
    end else if (m_requesting) begin
      if (redir) begin m_pc = tgt; m_stale = 1; end
      if (req_ready) begin m_requesting = 0; m_accepted = 1; end
    end else begin
      if (req_done) begin
        if (redir) m_pc = tgt;
        else if (!m_stale) m_pc = m_pc + FB;
        m_keep = !m_stale && !redir;
        m_drop = !m_keep;
        m_stale = 0;
        m_accepted = 0;
      end else if (redir) begin
        m_pc = tgt;
        m_stale = 1;
      end
    end
  endtask

  task automatic compare();
    check("req_valid", 64'(req_valid), 64'(m_requesting));
    check("req_index", 64'(req_index), 64'(m_idx));
    check("resp_keep", 64'(resp_keep), 64'(m_keep));
    check("resp_drop", 64'(resp_drop), 64'(m_drop));
    check("can_fetch", 64'(can_fetch_inst), 64'(!m_requesting && !m_accepted));
    check("cur_pc", 64'(cur_pc), 64'(m_pc));
  endtask

  task automatic clr();
    fetch_inst = 0; interrupt_valid = 0; redirect_valid = 0;
    req_ready = 0; req_done = 0;
  endtask

  // One clock: model predicts, DUT clocks, outputs sampled 1ns after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare();
    check("keep_drop_excl", 64'(resp_keep & resp_drop), 64'(0));
    clr();
  endtask

  task automatic do_fetch_accept();
    fetch_inst = 1; cycle();
    req_ready = 1; cycle();
  endtask

  function automatic logic [PC_W-1:0] rand_addr();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    if ($urandom_range(0, 7) == 0) r[PC_W-1:12] = '1;
    return r[PC_W-1:0];
  endfunction

  initial begin
    clr();
    interrupt_addr = '0;
    redirect_addr = '0;
    boot_addr = 48'h1000_0000_0048;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare();
    check("t1_pc", 64'(cur_pc), 64'h1000_0000_0040);
    rst_n = 1;
    cycle();

    // Fetch with ready on the third request cycle, done four cycles later.
    fetch_inst = 1; cycle();
    cycle();
    cycle();
    req_ready = 1; cycle();
    repeat (3) cycle();
    req_done = 1; cycle();
    check("t2_keep", 64'(resp_keep), 64'(1));
    check("t2_pc", 64'(cur_pc), 64'h1000_0000_0080);

    // Redirect in WAIT, then completion is stale.
    do_fetch_accept();
    redirect_valid = 1; redirect_addr = 48'h2005; cycle();
    req_done = 1; cycle();
    check("t3_drop", 64'(resp_drop), 64'(1));
    check("t3_pc", 64'(cur_pc), 64'h2000);

    // Interrupt and redirect together with done: interrupt wins.
    do_fetch_accept();
    interrupt_valid = 1; interrupt_addr = 48'h8000;
    redirect_valid = 1; redirect_addr = 48'h4000;
    req_done = 1; cycle();
    check("t4_drop", 64'(resp_drop), 64'(1));
    check("t4_pc", 64'(cur_pc), 64'h8000);

    // PC wrap at the top of the address space.
    redirect_valid = 1; redirect_addr = 48'hFFFF_FFFF_FFC0; cycle();
    do_fetch_accept();
    req_done = 1; cycle();
    check("t5_wrap_pc", 64'(cur_pc), 64'h0);
    // Redirect alongside fetch_inst in IDLE issues nothing.
    fetch_inst = 1; redirect_valid = 1; redirect_addr = 48'h3000; cycle();
    check("t5_no_req", 64'(req_valid), 64'(0));
    check("t5_pc", 64'(cur_pc), 64'h3000);

    // Reset in REQ returns to IDLE at once; a late done is ignored.
    fetch_inst = 1; cycle();
    rst_n = 0;
    #1;
    model_reset();
    check("t6_valid", 64'(req_valid), 64'(0));
    check("t6_can", 64'(can_fetch_inst), 64'(1));
    compare();
    @(posedge clk);
    #1;
    rst_n = 1;
    req_done = 1; cycle();
    check("t6_no_pulse", 64'(resp_keep | resp_drop), 64'(0));

    // Randomized traffic, including occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        boot_addr = rand_addr();
        rst_n = 0;
        #1;
        model_reset();
        compare();
        @(posedge clk);
        #1;
        rst_n = 1;
      end
      fetch_inst      = ($urandom_range(0, 1) == 0);
      req_ready       = ($urandom_range(0, 9) < 4);
      req_done        = ($urandom_range(0, 9) < 3);
      redirect_valid  = ($urandom_range(0, 99) < 8);
      interrupt_valid = ($urandom_range(0, 99) < 4);
      redirect_addr   = rand_addr();
      interrupt_addr  = rand_addr();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
